// File: rtl/dostring_scroll.sv
// LED-string frame generator: START word, STRING_SIZE scrolling palette words and an END word per
// frame, handed to the doled SPI driver over a start/busy handshake, with optional bouncing marker.
module dostring_scroll #(
    parameter int STRING_SIZE = 47,
    parameter int SEG_SIZE    = 15,
    parameter int NUM_SEG     = 7,
    parameter int SCROLL_STEP = 1
) (
    input  logic        dostring_scroll_clk,
    input  logic        dostring_scroll_reset,
    input  logic        enable,
    input  logic        mode,
    input  logic        scroll_dir,
    input  logic [1:0]  bright_shift,
    input  logic        doled_busy,
    output logic        led_start,
    output logic [1:0]  type_out,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {S_WAIT, S_LOAD, S_START, S_NEXT, S_FRAME} state_t;

    localparam logic [8:0] IDX_LAST = 9'(STRING_SIZE + 1);
    localparam logic [8:0] SEG_SZ   = 9'(SEG_SIZE);
    localparam logic [8:0] STEP     = 9'(SCROLL_STEP);
    localparam logic [2:0] SEG_LAST = 3'(NUM_SEG - 1);
    localparam logic [7:0] WAVE_MAX = 8'(STRING_SIZE);

    function automatic logic [23:0] palette(input logic [2:0] s);
        case (s)
            3'd0:    return 24'h800280;
            3'd1:    return 24'h0202F0;
            3'd2:    return 24'h028080;
            3'd3:    return 24'h02F002;
            3'd4:    return 24'hF08002;
            3'd5:    return 24'hC04002;
            default: return 24'hF00202;
        endcase
    endfunction

    function automatic logic [23:0] dim(input logic [23:0] c, input logic [1:0] sh);
        return {c[23:16] >> sh, c[15:8] >> sh, c[7:0] >> sh};
    endfunction

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [2:0]  seg_q, seg_d, off_seg_q, off_seg_d, off_seg_n;
    logic [7:0]  pos_q, pos_d, off_pos_q, off_pos_d, off_pos_n;
    logic [7:0]  wave_pos_q, wave_pos_d, wave_pos_n;
    logic        wave_up_q, wave_up_d, wave_up_n;
    logic        mode_q, mode_d, dir_q, dir_d;
    logic [1:0]  shift_q, shift_d;
    logic        led_start_q, led_start_d;
    logic [1:0]  type_q, type_d;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [8:0]  pos_inc, off_sum;

    // Next frame offset and marker position, used only when S_FRAME commits them.
    always_comb begin
        off_seg_n  = off_seg_q;
        off_pos_n  = off_pos_q;
        off_sum    = {1'b0, off_pos_q} + STEP;
        wave_pos_n = wave_pos_q;
        wave_up_n  = wave_up_q;
        if (!dir_q) begin
            if (off_sum >= SEG_SZ) begin
                off_pos_n = 8'(off_sum - SEG_SZ);
                off_seg_n = (off_seg_q == SEG_LAST) ? 3'd0 : off_seg_q + 3'd1;
            end else begin
                off_pos_n = 8'(off_sum);
            end
        end else begin
            if ({1'b0, off_pos_q} < STEP) begin
                off_pos_n = 8'({1'b0, off_pos_q} + SEG_SZ - STEP);
                off_seg_n = (off_seg_q == 3'd0) ? SEG_LAST : off_seg_q - 3'd1;
            end else begin
                off_pos_n = 8'({1'b0, off_pos_q} - STEP);
            end
        end
        if (WAVE_MAX > 8'd1) begin
            if (wave_up_q) begin
                if (wave_pos_q >= WAVE_MAX) begin
                    wave_pos_n = wave_pos_q - 8'd1;
                    wave_up_n  = 1'b0;
                end else begin
                    wave_pos_n = wave_pos_q + 8'd1;
                end
            end else if (wave_pos_q <= 8'd1) begin
                wave_pos_n = wave_pos_q + 8'd1;
                wave_up_n  = 1'b1;
            end else begin
                wave_pos_n = wave_pos_q - 8'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        seg_d         = seg_q;
        pos_d         = pos_q;
        off_seg_d     = off_seg_q;
        off_pos_d     = off_pos_q;
        wave_pos_d    = wave_pos_q;
        wave_up_d     = wave_up_q;
        mode_d        = mode_q;
        dir_d         = dir_q;
        shift_d       = shift_q;
        led_start_d   = led_start_q;
        type_d        = type_q;
        rgb_d         = rgb_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        pos_inc       = {1'b0, pos_q} + 9'd1;
        case (state_q)
            S_WAIT: begin
                if (!doled_busy && (idx_q != 9'd0 || enable)) begin
                    if (idx_q == 9'd0) begin
                        mode_d  = mode;
                        dir_d   = scroll_dir;
                        shift_d = bright_shift;
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                led_start_d = 1'b1;
                state_d     = S_START;
                if (idx_q == 9'd0) begin
                    type_d = 2'd0;
                    rgb_d  = 24'h000000;
                end else if (idx_q == IDX_LAST) begin
                    type_d = 2'd2;
                    rgb_d  = 24'hFFFFFF;
                end else begin
                    type_d = 2'd1;
                    rgb_d  = (mode_q && idx_q == {1'b0, wave_pos_q}) ? dim(24'hF0F0F0, shift_q)
                                                                      : dim(palette(seg_q), shift_q);
                end
            end
            S_START: begin
                // Dropping the request on the edge that sees busy keeps it from being taken twice.
                if (doled_busy) begin
                    led_start_d = 1'b0;
                    state_d     = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q != 9'd0 && idx_q != IDX_LAST) begin
                    if (pos_inc == SEG_SZ) begin
                        pos_d = 8'd0;
                        seg_d = (seg_q == SEG_LAST) ? 3'd0 : seg_q + 3'd1;
                    end else begin
                        pos_d = 8'(pos_inc);
                    end
                end
                if (idx_q == IDX_LAST) begin
                    idx_d         = 9'd0;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = S_FRAME;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = S_WAIT;
                end
            end
            S_FRAME: begin
                off_seg_d  = off_seg_n;
                off_pos_d  = off_pos_n;
                seg_d      = off_seg_n;
                pos_d      = off_pos_n;
                wave_pos_d = wave_pos_n;
                wave_up_d  = wave_up_n;
                state_d    = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge dostring_scroll_clk or posedge dostring_scroll_reset) begin
        if (dostring_scroll_reset) begin
            state_q       <= S_WAIT;
            idx_q         <= 9'd0;
            seg_q         <= 3'd0;
            pos_q         <= 8'd0;
            off_seg_q     <= 3'd0;
            off_pos_q     <= 8'd0;
            wave_pos_q    <= 8'd1;
            wave_up_q     <= 1'b1;
            mode_q        <= 1'b0;
            dir_q         <= 1'b0;
            shift_q       <= 2'd0;
            led_start_q   <= 1'b0;
            type_q        <= 2'd0;
            rgb_q         <= 24'h000000;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            pos_q         <= pos_d;
            off_seg_q     <= off_seg_d;
            off_pos_q     <= off_pos_d;
            wave_pos_q    <= wave_pos_d;
            wave_up_q     <= wave_up_d;
            mode_q        <= mode_d;
            dir_q         <= dir_d;
            shift_q       <= shift_d;
            led_start_q   <= led_start_d;
            type_q        <= type_d;
            rgb_q         <= rgb_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign led_start   = led_start_q;
    assign type_out    = type_q;
    assign red_out     = rgb_q[23:16];
    assign green_out   = rgb_q[15:8];
    assign blue_out    = rgb_q[7:0];
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dostring_scroll.sv
// Directed bench for dostring_scroll: a busy-holding driver model logs every requested word and
// the main sequence compares logged frames against hand-computed palette words.
module tb_dostring_scroll;

    localparam logic [23:0] P  = 24'h800280;
    localparam logic [23:0] B  = 24'h0202F0;
    localparam logic [23:0] C  = 24'h028080;
    localparam logic [23:0] PD = 24'h400140;
    localparam logic [23:0] BD = 24'h010178;
    localparam logic [23:0] WD = 24'h787878;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        scroll_dir = 1'b0;
    logic [1:0]  bright_shift = 2'd0;
    logic        doled_busy = 1'b0;
    logic        led_start;
    logic [1:0]  type_out;
    logic [7:0]  red_out, green_out, blue_out;
    logic        frame_done;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_err = 0;
    int pre_delay = 0;
    int req_count = 0;
    int fd_pulses = 0;
    logic [25:0] words[$];

    dostring_scroll #(.STRING_SIZE(4), .SEG_SIZE(2), .NUM_SEG(3), .SCROLL_STEP(1)) dut (
        .dostring_scroll_clk(clk), .dostring_scroll_reset(rst), .enable(enable), .mode(mode),
        .scroll_dir(scroll_dir), .bright_shift(bright_shift), .doled_busy(doled_busy),
        .led_start(led_start), .type_out(type_out), .red_out(red_out), .green_out(green_out),
        .blue_out(blue_out), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver model: takes a request, optionally delays busy, then holds busy for 3 cycles.
    task automatic driver();
        forever begin
            @(posedge clk); #1;
            if (led_start && !doled_busy && !rst) begin
                words.push_back({type_out, red_out, green_out, blue_out});
                req_count++;
                for (int i = 0; i < pre_delay; i++) begin
                    @(posedge clk); #1;
                    chk("hold_start", 32'(led_start), 32'd1);
                end
                doled_busy = 1'b1;
                @(posedge clk); #1;
                if (!rst) chk("start_drop", 32'(led_start), 32'd0);
                repeat (2) @(posedge clk);
                #1 doled_busy = 1'b0;
            end
        end
    endtask

    task automatic wait_frame(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            if (frame_done) ok = 1'b1;
        end
        @(negedge clk); #1;
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL %s_timeout observed=no frame_done expected=frame_done", tag);
        end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] e1, input logic [23:0] e2,
                               input logic [23:0] e3, input logic [23:0] e4);
        logic [25:0] exp[6];
        logic [25:0] w;
        exp = '{26'h0, {2'd1, e1}, {2'd1, e2}, {2'd1, e3}, {2'd1, e4}, {2'd2, 24'hFFFFFF}};
        chk({tag, "_nwords"}, 32'(words.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (words.size() > 0) w = words.pop_front();
            else w = '1;
            chk($sformatf("%s_w%0d", tag, i), 32'(w), 32'(exp[i]));
        end
    endtask

    task automatic white_idx(output int wi);
        logic [25:0] w;
        wi = 0;
        for (int i = 0; i < 6; i++) begin
            if (words.size() > 0) w = words.pop_front();
            else w = '1;
            if (w[23:0] == WD) wi = i;
        end
    endtask

    task automatic reset_dut();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        words.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int fd_base;
        int wi;
        int exp_w[6];
        exp_w = '{2, 3, 4, 3, 2, 1};
        fork driver(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led_start", 32'(led_start), 32'd0);
        chk("rst_type", 32'(type_out), 32'd0);
        chk("rst_rgb", {8'd0, red_out, green_out, blue_out}, 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Forward rainbow and scroll period
        wait_frame("f0");
        check_frame("fwd_f0", P, P, B, B);
        chk("fwd_count1", 32'(frame_count), 32'd1);
        chk("fwd_pulses1", 32'(fd_pulses), 32'd1);
        wait_frame("f1");
        check_frame("fwd_f1", P, B, B, C);
        for (int f = 2; f < 6; f++) begin
            wait_frame("fmid");
            chk($sformatf("fwd_f%0d_nwords", f), 32'(words.size()), 32'd6);
            words.delete();
        end
        wait_frame("f6");
        check_frame("fwd_f6", P, P, B, B);
        chk("fwd_count7", 32'(frame_count), 32'd7);
        chk("fwd_pulses7", 32'(fd_pulses), 32'd7);

        // Handshake with delayed busy
        pre_delay = 5;
        wait_frame("f7");
        check_frame("hs_f7", P, B, B, C);
        pre_delay = 0;

        // Enable dropped mid-frame
        base = req_count;
        for (int i = 0; i < 500 && req_count < base + 2; i++) @(posedge clk);
        #1 enable = 1'b0;
        wait_frame("f8");
        check_frame("en_f8", B, B, C, C);
        base = req_count;
        repeat (100) @(posedge clk);
        #1;
        chk("en_parked_reqs", 32'(req_count), 32'(base));
        chk("en_parked_start", 32'(led_start), 32'd0);
        enable = 1'b1;
        wait_frame("f9");
        check_frame("en_f9", B, C, C, P);

        // Reset asserted while the driver is busy
        for (int i = 0; i < 500 && !doled_busy; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("arst_led_start", 32'(led_start), 32'd0);
        chk("arst_type", 32'(type_out), 32'd0);
        chk("arst_rgb", {8'd0, red_out, green_out, blue_out}, 32'd0);
        chk("arst_count", 32'(frame_count), 32'd0);
        fd_base = fd_pulses;
        repeat (3) @(posedge clk);
        words.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_frame("ar0");
        check_frame("arst_f0", P, P, B, B);
        chk("arst_count1", 32'(frame_count), 32'd1);
        chk("arst_pulses", 32'(fd_pulses - fd_base), 32'd1);

        // Backward scroll
        scroll_dir = 1'b1;
        reset_dut();
        wait_frame("b0");
        check_frame("bwd_f0", P, P, B, B);
        wait_frame("b1");
        check_frame("bwd_f1", C, P, P, B);
        wait_frame("b2");
        check_frame("bwd_f2", C, C, P, P);

        // Wave marker with dimming
        scroll_dir = 1'b0;
        mode = 1'b1;
        bright_shift = 2'd1;
        reset_dut();
        wait_frame("w0");
        check_frame("wave_f0", WD, PD, BD, BD);
        for (int f = 1; f <= 6; f++) begin
            wait_frame("wn");
            white_idx(wi);
            chk($sformatf("wave_f%0d_idx", f), 32'(wi), 32'(exp_w[f - 1]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
